// File: rtl/movewide_unit.sv
// ---------------------------------------------------------------------------
// movewide_unit
//
// Multi-cycle move-wide execution engine (MOVZ / MOVN / MOVK) with a
// start/busy/done handshake towards the control unit.
//
//   MOVZ : rd = imm << (hw*SLICE_WIDTH)
//   MOVN : rd = ~(imm << (hw*SLICE_WIDTH))
//   MOVK : rd = rd with slice hw replaced by imm (read-modify-write through
//          the register file ports; one READ cycle then one WRITE cycle)
//
// Ports
//   clock, reset        : rising-edge clock, synchronous active-high reset
//   start               : request, accepted only while idle
//   opc                 : 00 MOVN, 10 MOVZ, 11 MOVK, 01 reserved
//   hw                  : slice index, shift = hw*SLICE_WIDTH
//   imm                 : SLICE_WIDTH-bit immediate
//   rd                  : destination register
//   busy                : high whenever the engine is not idle
//   done                : one-cycle completion pulse
//   illegal             : one-cycle pulse for the reserved opcode
//   pc_inc              : one-cycle pulse requesting PC <= PC+4
//   rf_sa / rf_rd_data  : register file read port A (combinational read)
//   rf_da / rf_w /
//   rf_wdata            : register file write port
//
// Every output is decoded from the state register and the latched
// operands only, so no combinational path exists from start/opc/imm to
// any output.
// ---------------------------------------------------------------------------
module movewide_unit #(
  parameter int DATA_WIDTH     = 64,
  parameter int SLICE_WIDTH    = 16,
  parameter int REG_ADDR_WIDTH = 5,
  localparam int NUM_SLICES    = DATA_WIDTH / SLICE_WIDTH,
  localparam int SH_WIDTH      = $clog2(NUM_SLICES)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                opc,
  input  logic [SH_WIDTH-1:0]       hw,
  input  logic [SLICE_WIDTH-1:0]    imm,
  input  logic [REG_ADDR_WIDTH-1:0] rd,
  output logic                      busy,
  output logic                      done,
  output logic                      illegal,
  output logic                      pc_inc,
  output logic [REG_ADDR_WIDTH-1:0] rf_sa,
  input  logic [DATA_WIDTH-1:0]     rf_rd_data,
  output logic [REG_ADDR_WIDTH-1:0] rf_da,
  output logic                      rf_w,
  output logic [DATA_WIDTH-1:0]     rf_wdata
);

  localparam logic [1:0] OPC_MOVN = 2'b00;
  localparam logic [1:0] OPC_RSVD = 2'b01;
  localparam logic [1:0] OPC_MOVZ = 2'b10;
  localparam logic [1:0] OPC_MOVK = 2'b11;

  // The all-ones register address is the zero register: writes are dropped.
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t                    state_reg, state_next;
  logic [SH_WIDTH-1:0]       hw_reg, hw_next;
  logic [SLICE_WIDTH-1:0]    imm_reg, imm_next;
  logic [REG_ADDR_WIDTH-1:0] rd_reg, rd_next;
  logic [DATA_WIDTH-1:0]     res_reg, res_next;

  // -------------------------------------------------------------------------
  // Slice placement.
  // In IDLE the result for MOVZ/MOVN is computed from the live request so
  // that it is ready on the acceptance edge; in READ the MOVK merge uses the
  // latched operands. A per-slice decoder replaces a barrel shift: placing
  // imm into slice hw is exactly imm << (hw*SLICE_WIDTH) at DATA_WIDTH width.
  // -------------------------------------------------------------------------
  logic [SH_WIDTH-1:0]    sh_hw;
  logic [SLICE_WIDTH-1:0] sh_imm;
  logic [NUM_SLICES-1:0]  slice_sel;
  logic [DATA_WIDTH-1:0]  placed_imm;
  logic [DATA_WIDTH-1:0]  keep_mask;

  assign sh_hw  = (state_reg == ST_IDLE) ? hw  : hw_reg;
  assign sh_imm = (state_reg == ST_IDLE) ? imm : imm_reg;

  generate
    for (genvar gi = 0; gi < NUM_SLICES; gi++) begin : g_slice
      assign slice_sel[gi] = (sh_hw == SH_WIDTH'(gi));
      assign placed_imm[gi*SLICE_WIDTH +: SLICE_WIDTH] =
        slice_sel[gi] ? sh_imm : {SLICE_WIDTH{1'b0}};
      // Mask keeps every slice of the old register value except slice hw.
      assign keep_mask[gi*SLICE_WIDTH +: SLICE_WIDTH] =
        slice_sel[gi] ? {SLICE_WIDTH{1'b0}} : {SLICE_WIDTH{1'b1}};
    end
  endgenerate

  // -------------------------------------------------------------------------
  // State and operand registers.
  // The opcode itself is not kept: once accepted, the state (READ, WRITE,
  // FAULT) plus the precomputed res_reg fully encode what remains to do.
  // -------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      hw_reg    <= '0;
      imm_reg   <= '0;
      rd_reg    <= '0;
      res_reg   <= '0;
    end else begin
      state_reg <= state_next;
      hw_reg    <= hw_next;
      imm_reg   <= imm_next;
      rd_reg    <= rd_next;
      res_reg   <= res_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state and operand-latch logic.
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    hw_next    = hw_reg;
    imm_next   = imm_reg;
    rd_next    = rd_reg;
    res_next   = res_reg;

    case (state_reg)
      ST_IDLE: begin
        if (start) begin
          hw_next  = hw;
          imm_next = imm;
          rd_next  = rd;
          case (opc)
            OPC_MOVK: state_next = ST_READ;
            OPC_MOVZ: begin
              res_next   = placed_imm;
              state_next = ST_WRITE;
            end
            OPC_MOVN: begin
              res_next   = ~placed_imm;
              state_next = ST_WRITE;
            end
            OPC_RSVD: state_next = ST_FAULT;
            default:  state_next = ST_FAULT;
          endcase
        end
      end

      ST_READ: begin
        // Register file value is taken as presented this cycle (no forwarding).
        res_next   = (rf_rd_data & keep_mask) | placed_imm;
        state_next = ST_WRITE;
      end

      ST_WRITE: state_next = ST_IDLE;
      ST_FAULT: state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode (registered state and operands only).
  // -------------------------------------------------------------------------
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    illegal  = 1'b0;
    pc_inc   = 1'b0;
    rf_sa    = '0;
    rf_da    = '0;
    rf_w     = 1'b0;
    rf_wdata = '0;

    case (state_reg)
      ST_IDLE: begin
      end
      ST_READ: begin
        busy  = 1'b1;
        rf_sa = rd_reg;
      end
      ST_WRITE: begin
        busy     = 1'b1;
        done     = 1'b1;
        pc_inc   = 1'b1;
        rf_da    = rd_reg;
        rf_wdata = res_reg;
        rf_w     = (rd_reg != ZERO_REG);
      end
      ST_FAULT: begin
        busy    = 1'b1;
        done    = 1'b1;
        illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_movewide_unit.sv
module tb_movewide_unit;

  // ---------------- 64/16 instance ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  opc = 2'b00;
  logic [1:0]  hw = 2'd0;
  logic [15:0] imm = 16'h0;
  logic [4:0]  rd = 5'd0;
  logic [63:0] rf_rd_data = 64'h0;
  logic        busy, done, illegal, pc_inc, rf_w;
  logic [4:0]  rf_sa, rf_da;
  logic [63:0] rf_wdata;

  movewide_unit #(.DATA_WIDTH(64), .SLICE_WIDTH(16), .REG_ADDR_WIDTH(5)) u_dut (
    .clock(clock), .reset(reset), .start(start), .opc(opc), .hw(hw),
    .imm(imm), .rd(rd), .busy(busy), .done(done), .illegal(illegal),
    .pc_inc(pc_inc), .rf_sa(rf_sa), .rf_rd_data(rf_rd_data), .rf_da(rf_da),
    .rf_w(rf_w), .rf_wdata(rf_wdata)
  );

  // ---------------- 32/8 instance ----------------
  logic        start8 = 1'b0;
  logic [1:0]  opc8 = 2'b00;
  logic [1:0]  hw8 = 2'd0;
  logic [7:0]  imm8 = 8'h0;
  logic [4:0]  rd8 = 5'd0;
  logic [31:0] rf_rd_data8 = 32'h0;
  logic        busy8, done8, illegal8, pc_inc8, rf_w8;
  logic [4:0]  rf_sa8, rf_da8;
  logic [31:0] rf_wdata8;

  movewide_unit #(.DATA_WIDTH(32), .SLICE_WIDTH(8), .REG_ADDR_WIDTH(5)) u_dut8 (
    .clock(clock), .reset(reset), .start(start8), .opc(opc8), .hw(hw8),
    .imm(imm8), .rd(rd8), .busy(busy8), .done(done8), .illegal(illegal8),
    .pc_inc(pc_inc8), .rf_sa(rf_sa8), .rf_rd_data(rf_rd_data8), .rf_da(rf_da8),
    .rf_w(rf_w8), .rf_wdata(rf_wdata8)
  );

  always #5 clock = ~clock;

  int total_checks = 0;
  int passed_checks = 0;

  typedef struct {
    logic [1:0]  opc;
    logic [1:0]  hw;
    logic [15:0] imm;
    logic [4:0]  rd;
    logic [63:0] rf_data;
    logic [63:0] exp_wdata;
    logic [4:0]  exp_da;
    logic        exp_w;
    logic        exp_ill;
    logic        exp_pc;
  } vec_t;

  vec_t vecs[10];

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passed_checks++;
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"},     64'(busy),     64'h0);
    chk({tag, " done"},     64'(done),     64'h0);
    chk({tag, " illegal"},  64'(illegal),  64'h0);
    chk({tag, " pc_inc"},   64'(pc_inc),   64'h0);
    chk({tag, " rf_w"},     64'(rf_w),     64'h0);
    chk({tag, " rf_sa"},    64'(rf_sa),    64'h0);
    chk({tag, " rf_da"},    64'(rf_da),    64'h0);
    chk({tag, " rf_wdata"}, rf_wdata,      64'h0);
  endtask

  initial begin
    int n_done, n_ill, n_a, n_b;
    logic [1:0] rst_ops[3];

    vecs[0] = '{2'b10, 2'd2, 16'hBEEF, 5'd3, 64'h0,
                64'h0000_BEEF_0000_0000, 5'd3, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{2'b00, 2'd2, 16'hBEEF, 5'd3, 64'h0,
                64'hFFFF_4110_FFFF_FFFF, 5'd3, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{2'b11, 2'd1, 16'hABCD, 5'd7, 64'h1122_3344_5566_7788,
                64'h1122_3344_ABCD_7788, 5'd7, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{2'b11, 2'd3, 16'hABCD, 5'd7, 64'h1122_3344_5566_7788,
                64'hABCD_3344_5566_7788, 5'd7, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{2'b10, 2'd0, 16'h1234, 5'd0, 64'h0,
                64'h0000_0000_0000_1234, 5'd0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{2'b00, 2'd0, 16'h0000, 5'd1, 64'h0,
                64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{2'b10, 2'd3, 16'hFFFF, 5'd31, 64'h0,
                64'hFFFF_0000_0000_0000, 5'd31, 1'b0, 1'b0, 1'b1};
    vecs[7] = '{2'b11, 2'd0, 16'h0000, 5'd2, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_0000, 5'd2, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{2'b01, 2'd1, 16'h5555, 5'd9, 64'h0,
                64'h0, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[9] = '{2'b00, 2'd3, 16'h8000, 5'd5, 64'h0,
                64'h7FFF_FFFF_FFFF_FFFF, 5'd5, 1'b1, 1'b0, 1'b1};

    // Power-on reset.
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    check_idle("por");

    // Reset held 3 cycles while in WRITE, READ and FAULT.
    rst_ops[0] = 2'b10;
    rst_ops[1] = 2'b11;
    rst_ops[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      start = 1'b1; opc = rst_ops[k]; hw = 2'd1; imm = 16'hA5A5; rd = 5'd4;
      rf_rd_data = 64'hDEAD_BEEF_CAFE_F00D;
      step();
      start = 1'b0;
      chk($sformatf("rst%0d busy before reset", k), 64'(busy), 64'h1);
      reset = 1'b1;
      repeat (3) step();
      reset = 1'b0;
      check_idle($sformatf("rst%0d after", k));
      step();
      check_idle($sformatf("rst%0d after+1", k));
    end

    // Table-driven single operations.
    for (int i = 0; i < 10; i++) begin
      start = 1'b1; opc = vecs[i].opc; hw = vecs[i].hw; imm = vecs[i].imm;
      rd = vecs[i].rd; rf_rd_data = vecs[i].rf_data;
      step();
      // Inputs may change freely while busy.
      start = 1'b0; opc = 2'b01; hw = 2'd3; imm = 16'hFFFF; rd = 5'd31;
      chk($sformatf("v%0d busy", i), 64'(busy), 64'h1);
      if (vecs[i].opc == 2'b11) begin
        chk($sformatf("v%0d rf_sa", i), 64'(rf_sa), 64'(vecs[i].rd));
        chk($sformatf("v%0d read done", i), 64'(done), 64'h0);
        chk($sformatf("v%0d read rf_w", i), 64'(rf_w), 64'h0);
        step();
      end
      chk($sformatf("v%0d done", i),     64'(done),    64'h1);
      chk($sformatf("v%0d rf_w", i),     64'(rf_w),    64'(vecs[i].exp_w));
      chk($sformatf("v%0d rf_da", i),    64'(rf_da),   64'(vecs[i].exp_da));
      chk($sformatf("v%0d rf_wdata", i), rf_wdata,     vecs[i].exp_wdata);
      chk($sformatf("v%0d illegal", i),  64'(illegal), 64'(vecs[i].exp_ill));
      chk($sformatf("v%0d pc_inc", i),   64'(pc_inc),  64'(vecs[i].exp_pc));
      step();
      chk($sformatf("v%0d idle busy", i), 64'(busy), 64'h0);
      chk($sformatf("v%0d idle done", i), 64'(done), 64'h0);
    end

    // Start held high every cycle; busy-cycle requests are reserved opcodes
    // and must be dropped. Accepts at cycles 0,2,5,7,10,... (period 5).
    n_done = 0; n_ill = 0; n_a = 0; n_b = 0;
    rf_rd_data = 64'h0; rd = 5'd4;
    for (int c = 0; c < 20; c++) begin
      start = 1'b1;
      case (c % 5)
        0:       begin opc = 2'b10; hw = 2'd0; imm = 16'h0011; end
        2:       begin opc = 2'b11; hw = 2'd1; imm = 16'h0022; end
        default: begin opc = 2'b01; hw = 2'd3; imm = 16'hFFFF; end
      endcase
      if (done) n_done++;
      if (illegal) n_ill++;
      if (rf_w && rf_wdata == 64'h11) n_a++;
      if (rf_w && rf_wdata == 64'h0022_0000) n_b++;
      step();
    end
    start = 1'b0;
    chk("hs done count", 64'(n_done), 64'd8);
    chk("hs illegal count", 64'(n_ill), 64'd0);
    chk("hs movz writes", 64'(n_a), 64'd4);
    chk("hs movk writes", 64'(n_b), 64'd4);
    step();
    check_idle("hs end");

    // Reset asserted during READ aborts the MOVK.
    start = 1'b1; opc = 2'b11; hw = 2'd2; imm = 16'h1357; rd = 5'd6;
    rf_rd_data = 64'h0123_4567_89AB_CDEF;
    step();
    start = 1'b0;
    chk("rdrst rf_sa", 64'(rf_sa), 64'd6);
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rdrst c%0d rf_w", k), 64'(rf_w), 64'h0);
      chk($sformatf("rdrst c%0d busy", k), 64'(busy), 64'h0);
      chk($sformatf("rdrst c%0d done", k), 64'(done), 64'h0);
      step();
    end

    // 32-bit datapath with 8-bit slices.
    start8 = 1'b1; opc8 = 2'b11; hw8 = 2'd3; imm8 = 8'h5A; rd8 = 5'd10;
    rf_rd_data8 = 32'hFFFF_FFFF;
    step();
    start8 = 1'b0;
    chk("p8 movk rf_sa", 64'(rf_sa8), 64'd10);
    step();
    chk("p8 movk rf_wdata", 64'(rf_wdata8), 64'h5AFF_FFFF);
    chk("p8 movk rf_w", 64'(rf_w8), 64'h1);
    chk("p8 movk done", 64'(done8), 64'h1);
    step();
    start8 = 1'b1; opc8 = 2'b10; hw8 = 2'd1; imm8 = 8'h5A; rd8 = 5'd11;
    step();
    start8 = 1'b0;
    chk("p8 movz rf_wdata", 64'(rf_wdata8), 64'h0000_5A00);
    chk("p8 movz rf_da", 64'(rf_da8), 64'd11);
    step();
    chk("p8 idle busy", 64'(busy8), 64'h0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
